// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants: instruction size, default reset PC
// and the buffered fetch entry carried from the memory response to decode.
package proc_pkg;

  localparam int INST_BYTES   = 4;
  localparam int PC_START_DEF = 128;
  localparam int FE_ADDR_W    = 32;
  localparam int FE_DATA_W    = 32;

  typedef struct packed {
    logic [FE_ADDR_W-1:0] pc;
    logic [FE_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/proc_fetch_fifo.sv
// Prefetch FIFO of fetch entries; registered push, head visible one cycle
// after push (no bypass), flush overrides push and pop.
module proc_fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/proc_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order memory requests,
// prefetch buffering to decode and redirect with in-flight response dropping.
module proc_fetch_unit
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ISA_DPTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] PC_START = ADDR_WIDTH'(PC_START_DEF),
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_req_vld,
  output logic [ADDR_WIDTH-1:0]       o_req_addr,
  input  logic                        i_req_rdy,
  input  logic                        i_rsp_vld,
  input  logic [DATA_WIDTH-1:0]       i_rsp_data,
  output logic                        o_ivld,
  output logic [DATA_WIDTH-1:0]       o_instr,
  output logic [ADDR_WIDTH-1:0]       o_pc,
  output logic [$clog2(ISA_DPTH)-1:0] o_opcd,
  input  logic                        i_ird,
  input  logic                        i_redir,
  input  logic [ADDR_WIDTH-1:0]       i_redir_pc,
  output logic                        o_err
);

  localparam int OPW = $clog2(ISA_DPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int TW  = $clog2(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         outst_q;
  logic [CW-1:0]         outst_nxt;
  logic [CW-1:0]         drop_q;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           credit_use;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] trk [FIFO_DEPTH];
  logic [TW-1:0]         trk_wr;
  logic [TW-1:0]         trk_rd;
  fetch_entry_t          head;
  fetch_entry_t          push_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_now;
  logic                  req_acc;
  logic                  rsp_ok;
  logic                  push_now;
  logic                  unused_ok;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (p == TW'(FIFO_DEPTH - 1)) ? '0 : p + TW'(1);
  endfunction

  // A pop this cycle frees a slot, so credit looks through i_ird.
  assign pop_now    = ~fifo_empty & i_ird;
  assign credit_use = {1'b0, outst_q} + {1'b0, fifo_cnt} - (CW+1)'(pop_now);
  assign o_req_vld  = ~rst & (credit_use < (CW+1)'(FIFO_DEPTH));
  assign o_req_addr = pc_q;

  assign req_acc   = o_req_vld & i_req_rdy;
  assign rsp_ok    = i_rsp_vld & (outst_q != '0);
  assign push_now  = rsp_ok & (drop_q == '0) & ~i_redir;
  assign outst_nxt = outst_q + CW'(req_acc) - CW'(rsp_ok);

  assign push_entry.pc    = FE_ADDR_W'(trk[trk_rd]);
  assign push_entry.instr = FE_DATA_W'(i_rsp_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_START;
      outst_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      trk_wr  <= '0;
      trk_rd  <= '0;
    end else begin
      outst_q <= outst_nxt;
      if (i_redir)      pc_q <= {i_redir_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (req_acc) pc_q <= pc_q + ADDR_WIDTH'(INST_BYTES);
      // Everything still in flight after a redirect belongs to the old path.
      if (i_redir)                      drop_q <= outst_nxt;
      else if (rsp_ok && drop_q != '0)  drop_q <= drop_q - CW'(1);
      if (req_acc) trk_wr <= trk_inc(trk_wr);
      if (rsp_ok)  trk_rd <= trk_inc(trk_rd);
      if (i_rsp_vld && outst_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) trk[trk_wr] <= pc_q;
  end

  proc_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_now),
    .push_entry (push_entry),
    .pop        (pop_now & ~i_redir),
    .flush      (i_redir),
    .head       (head),
    .count      (fifo_cnt),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign o_ivld  = ~fifo_empty;
  assign o_instr = fifo_empty ? '0 : DATA_WIDTH'(head.instr);
  assign o_pc    = fifo_empty ? '0 : ADDR_WIDTH'(head.pc);
  assign o_opcd  = o_instr[OPW-1:0];
  assign o_err   = err_q;

  // Redirect targets are word aligned; occupancy is tracked by count instead.
  assign unused_ok = ^{i_redir_pc[1:0], fifo_full};

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Bench for proc_fetch_unit: directed cycle tables, corner sequences and a
// randomized run against a queue-based fetch model with an in-order memory.
module tb_proc_fetch_unit;
  import proc_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_req_vld;
  logic [31:0] o_req_addr;
  logic        i_req_rdy = 1'b0;
  logic        i_rsp_vld = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic        o_ivld;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [5:0]  o_opcd;
  logic        i_ird = 1'b0;
  logic        i_redir = 1'b0;
  logic [31:0] i_redir_pc = '0;
  logic        o_err;

  always #5 clk = ~clk;

  proc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .o_req_vld  (o_req_vld),
    .o_req_addr (o_req_addr),
    .i_req_rdy  (i_req_rdy),
    .i_rsp_vld  (i_rsp_vld),
    .i_rsp_data (i_rsp_data),
    .o_ivld     (o_ivld),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_opcd     (o_opcd),
    .i_ird      (i_ird),
    .i_redir    (i_redir),
    .i_redir_pc (i_redir_pc),
    .o_err      (o_err)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fly_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    bit rdy; bit ird; bit redir; logic [31:0] rpc;
    bit ex_rv; logic [31:0] ex_addr; bit ex_iv; logic [31:0] ex_pc;
  } vec_t;

  ent_t  m_fifo[$];
  fly_t  m_fly[$];
  mreq_t mem_q[$];
  vec_t  tbl[$];
  logic [31:0] m_pc;
  bit    m_err;
  int    cyc;
  int    lat;
  int    total = 0;
  int    bad = 0;
  logic        s_rv, s_iv, s_err;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hc3a5, a[7:0], a[7:0] ^ 8'h3c};
  endfunction

  function automatic vec_t mk(input bit rdy, input bit ird, input bit redir,
                              input logic [31:0] rpc, input bit rv,
                              input logic [31:0] addr, input bit iv,
                              input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.ird = ird; v.redir = redir; v.rpc = rpc;
    v.ex_rv = rv; v.ex_addr = addr; v.ex_iv = iv; v.ex_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model at negedge,
  // advance the model, then move to just after the next rising edge.
  task automatic step(input bit rdy, input bit ird, input bit redir,
                      input logic [31:0] rpc, input bit inj);
    bit pop, e_rv, acc;
    logic [31:0] e_pc, e_in;
    fly_t f;
    ent_t e;
    mreq_t r;
    i_req_rdy = rdy; i_ird = ird; i_redir = redir; i_redir_pc = rpc;
    i_rsp_vld = 1'b0; i_rsp_data = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      i_rsp_vld = 1'b1;
      i_rsp_data = instr_of(mem_q[0].addr);
      mem_q.delete(0);
    end else if (inj) begin
      i_rsp_vld = 1'b1;
    end
    pop  = (m_fifo.size() > 0) && ird;
    e_rv = (m_fly.size() + m_fifo.size() - int'(pop)) < DEPTH;
    e_pc = (m_fifo.size() > 0) ? m_fifo[0].pc : 32'h0;
    e_in = (m_fifo.size() > 0) ? m_fifo[0].instr : 32'h0;
    @(negedge clk);
    s_rv = o_req_vld; s_addr = o_req_addr; s_iv = o_ivld; s_pc = o_pc; s_err = o_err;
    chk("req_vld", 32'(o_req_vld), 32'(e_rv));
    chk("req_addr", o_req_addr, m_pc);
    chk("ivld", 32'(o_ivld), 32'(m_fifo.size() > 0));
    chk("pc", o_pc, e_pc);
    chk("instr", o_instr, e_in);
    chk("opcd", 32'(o_opcd), 32'(e_in[5:0]));
    chk("err", 32'(o_err), 32'(m_err));
    acc = e_rv && rdy;
    if (pop && !redir) m_fifo.delete(0);
    if (i_rsp_vld) begin
      if (m_fly.size() == 0) m_err = 1'b1;
      else begin
        f = m_fly.pop_front();
        if (!f.stale && !redir) begin
          e.pc = f.pc; e.instr = instr_of(f.pc);
          m_fifo.push_back(e);
        end
      end
    end
    if (acc) begin
      f.pc = m_pc; f.stale = 1'b0; m_fly.push_back(f);
      r.addr = m_pc; r.due = cyc + lat; mem_q.push_back(r);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_fly[i]) m_fly[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    i_req_rdy = 1'b0; i_ird = 1'b0; i_redir = 1'b0; i_redir_pc = '0;
    i_rsp_vld = 1'b0; i_rsp_data = '0;
    #1;
    chk("rst_req_vld", 32'(o_req_vld), 32'h0);
    chk("rst_ivld", 32'(o_ivld), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_opcd", 32'(o_opcd), 32'h0);
    m_fifo.delete(); m_fly.delete(); mem_q.delete();
    m_pc = 32'h80; m_err = 1'b0; lat = l;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].ird, tbl[i].redir, tbl[i].rpc, 1'b0);
      chk({nm, "_rv"}, 32'(s_rv), 32'(tbl[i].ex_rv));
      if (tbl[i].ex_rv) chk({nm, "_addr"}, s_addr, tbl[i].ex_addr);
      chk({nm, "_iv"}, 32'(s_iv), 32'(tbl[i].ex_iv));
      if (tbl[i].ex_iv) chk({nm, "_pc"}, s_pc, tbl[i].ex_pc);
    end
    tbl.delete();
  endtask

  task automatic fill_backpressure(input int rows);
    vec_t b[7];
    b[0] = mk(1, 0, 0, 0, 1, 32'h80, 0, 0);
    b[1] = mk(1, 0, 0, 0, 1, 32'h84, 0, 0);
    b[2] = mk(1, 0, 0, 0, 0, 0,      1, 32'h80);
    b[3] = mk(1, 0, 0, 0, 0, 0,      1, 32'h80);
    b[4] = mk(1, 1, 0, 0, 1, 32'h88, 1, 32'h80);
    b[5] = mk(1, 1, 0, 0, 1, 32'h8c, 1, 32'h84);
    b[6] = mk(1, 1, 0, 0, 1, 32'h90, 1, 32'h88);
    for (int i = 0; i < rows; i++) tbl.push_back(b[i]);
  endtask

  initial begin
    bit rdy, ird, redir, inj;
    logic [31:0] rpc;

    // Streaming with a 1-cycle memory: one instruction per cycle.
    do_reset(1);
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h84, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h88, 1, 32'h80));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h8c, 1, 32'h84));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h90, 1, 32'h88));
    run_tbl("stream");

    // Decode stalled: credit closes with two buffered, reopens with i_ird.
    do_reset(1);
    fill_backpressure(7);
    run_tbl("stall");

    // Memory not ready: address held.
    do_reset(1);
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 32'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h84, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h88, 1, 32'h80));
    run_tbl("nordy");

    // Redirect with two in flight on a 3-cycle memory.
    do_reset(3);
    tbl.push_back(mk(1, 1, 0, 0,        1, 32'h80,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        1, 32'h84,  0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h203,  0, 0,       0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        0, 0,       0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        1, 32'h204, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        0, 0,       0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        0, 0,       0, 0));
    tbl.push_back(mk(1, 1, 0, 0,        1, 32'h208, 1, 32'h200));
    run_tbl("redir");

    // Unsolicited response with a full FIFO: sticky error, contents kept.
    do_reset(1);
    fill_backpressure(4);
    run_tbl("fill");
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("unsol_err", 32'(s_err), 32'h1);
    chk("unsol_pc", s_pc, 32'h80);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("unsol_pop0", s_pc, 32'h80);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("unsol_pop1", s_pc, 32'h84);
    step(1'b1, 1'b1, 1'b1, 32'h400, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("unsol_sticky", 32'(s_err), 32'h1);

    // Reset mid-stream with a full FIFO, then restart from PC_START.
    do_reset(1);
    fill_backpressure(4);
    run_tbl("prefull");
    do_reset(1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_restart_rv", 32'(s_rv), 32'h1);
    chk("rst_restart_addr", s_addr, 32'h80);

    // Randomized traffic across memory latencies.
    for (int l = 1; l <= 3; l++) begin
      do_reset(l);
      for (int n = 0; n < 400; n++) begin
        rdy   = ($urandom % 4) != 0;
        ird   = ($urandom % 10) < 7;
        redir = ($urandom % 30) == 0;
        rpc   = (($urandom % 3) == 0) ? 32'hFFFF_FFF6 : $urandom;
        inj   = (l == 3) && (m_fly.size() == 0) && (mem_q.size() == 0) &&
                (($urandom % 50) == 0);
        step(rdy, ird, redir, rpc, inj);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_fetch_unit.md
Name: proc_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the processor's control/datapath pair.
- Holds the fetch PC and issues in-order read requests to instruction memory over a valid/ready request channel.
- Buffers returned instruction words in a small prefetch FIFO and hands them to decode with a valid/ready handshake; the decode ready is the controller's IR-enable.
- Supports a PC redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte address width of PC and request address.
- ISA_DPTH, 64, opcode space; o_opcd width = $clog2(ISA_DPTH).
- PC_START, 128, PC value after reset.
- FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum outstanding-plus-buffered credit (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- o_req_vld  out  1  fetch request valid.
- o_req_addr  out  ADDR_WIDTH  fetch byte address (word aligned).
- i_req_rdy  in  1  memory accepts request.
- i_rsp_vld  in  1  read data valid; responses arrive in order; no backpressure.
- i_rsp_data  in  DATA_WIDTH  instruction word.
- o_ivld  out  1  instruction available to decode.
- o_instr  out  DATA_WIDTH  FIFO head instruction.
- o_pc  out  ADDR_WIDTH  PC of o_instr.
- o_opcd  out  $clog2(ISA_DPTH)  o_instr[$clog2(ISA_DPTH)-1:0].
- i_ird  in  1  decode ready (IR enable); pop on o_ivld & i_ird.
- i_redir  in  1  redirect strobe.
- i_redir_pc  in  ADDR_WIDTH  redirect target.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset values (immediate, asynchronous):
  - fetch PC = PC_START.
  - FIFO empty; outstanding count = 0; drop count = 0.
  - o_req_vld = 0, o_ivld = 0, o_err = 0.
  - o_instr, o_pc, o_opcd = 0.
- Credit rule:
  - o_req_vld = (outstanding + fifo_count − pop_now) < FIFO_DEPTH, and drop count == 0 is not required.
  - pop_now = o_ivld & i_ird, so o_req_vld depends combinationally on i_ird. This dependency is intended.
  - o_req_vld does not depend on i_redir.
- Request:
  - o_req_addr = fetch PC.
  - On o_req_vld & i_req_rdy: PC += 4, outstanding +1.
  - PC wraps modulo 2^ADDR_WIDTH with no flag.
- Response:
  - Every i_rsp_vld decrements outstanding.
  - If drop count > 0, the word is discarded and drop count decrements.
  - Otherwise the word is pushed to the FIFO with its PC; a per-entry PC tracker holds the address of each outstanding request.
  - Credit guarantees the FIFO never overflows.
- i_rsp_vld with outstanding == 0: ignore data, set o_err (cleared only by rst).
- Latency:
  - Response pushed in cycle N → o_ivld = 1 in cycle N+1. There is no response-to-output bypass.
  - First o_req_vld = 1 in the first cycle after rst deasserts.
- Throughput: with a 1-cycle memory, i_req_rdy = 1 and i_ird = 1, the unit sustains one instruction per cycle.
- FIFO boundaries:
  - Simultaneous push and pop on a full FIFO is legal.
  - Push and pop on an empty FIFO: data appears the next cycle; no bypass.
  - Pointers wrap at FIFO_DEPTH.
- Redirect (i_redir = 1 in cycle R):
  - PC <= {i_redir_pc[ADDR_WIDTH-1:2], 2'b00}; the low bits are ignored.
  - FIFO flushed; o_ivld = 0 from R+1.
  - A pop in cycle R is a no-op from the fetch unit's view.
  - Drop count <= all requests still in flight after cycle R. This includes a request accepted in R and excludes a response arriving in R, which is itself discarded.
  - Requests may issue from the new PC from R+1, subject to credit.
  - Redirect while drop count > 0: recompute the drop count the same way (it is cumulative by construction).
- Reset mid-operation: all state cleared. Memory shares rst, so no stale responses are expected; any stale response sets o_err.

Decomposition:
- Shared package proc_pkg holds:
  - INST_BYTES = 4.
  - Default PC_START.
  - A fetch-entry struct typedef {pc, instr}.
- One sub-module, proc_fetch_fifo: a synchronous FIFO of fetch entries with push, pop, flush, count, full and empty.
- The PC, credit and drop logic stay in proc_fetch_unit.

Test Plan:
- Reset then run with 1-cycle memory, i_ird = 1:
  - Requests at 0x80, 0x84, 0x88…
  - o_ivld = 1 from the third cycle after reset release.
  - One instruction per cycle; o_pc matches each address.
- Hold i_ird = 0:
  - After 2 requests, o_req_vld = 0 with the FIFO full at 2 entries.
  - Raise i_ird: o_req_vld = 1 in the same cycle; order is preserved.
- i_req_rdy = 0 for 5 cycles: o_req_addr is held at 0x80 and the PC does not advance.
- Redirect to 0x203 while 2 requests are outstanding with a 3-cycle memory latency:
  - Both old responses are dropped; o_ivld stays 0 for them.
  - Next request address is 0x200; the first delivered o_pc is 0x200.
- Unsolicited i_rsp_vld with outstanding = 0 → o_err = 1 and stays 1 until rst; the FIFO is unchanged.
- Assert rst mid-stream with a full FIFO → o_ivld = 0 and o_req_vld = 0 immediately; after release, the next request address is 0x80.
